// File: rtl/seg7_bin2num_if.sv
// Producer-side bus of the binary-to-digit converter: start request, value,
// status flags and the six registered digit codes.
interface seg7_bin2num_if #(
  parameter int BIN_W = 20
) ();
  logic             load;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [4:0]       num0;
  logic [4:0]       num1;
  logic [4:0]       num2;
  logic [4:0]       num3;
  logic [4:0]       num4;
  logic [4:0]       num5;

  modport master (
    output load, bin_in,
    input  busy, done, ovf, num0, num1, num2, num3, num4, num5
  );

  modport slave (
    input  load, bin_in,
    output busy, done, ovf, num0, num1, num2, num3, num4, num5
  );
endinterface

// File: rtl/seg7_bin2num.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, with
// leading-zero blanking and overflow glyphs for a six-digit 7-segment display.
module seg7_bin2num #(
  parameter int BIN_W    = 20,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  seg7_bin2num_if.slave  bus
);

  localparam int              CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);
  localparam logic [4:0]       GLYPH_BLANK = 5'd16;
  localparam logic [4:0]       GLYPH_F     = 5'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_next_q, ovf_next_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       num_q [6];
  logic [4:0]       num_d [6];
  logic [23:0]      bcd_adj;
  logic [3:0]       digit;
  logic             lz;

  function automatic logic [23:0] dabble_adj(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = dabble_adj(bcd_q);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    digit      = 4'd0;
    lz         = 1'b1;
    for (int i = 0; i < 6; i++) num_d[i] = num_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          bin_d      = bus.bin_in;
          bcd_d      = '0;
          cnt_d      = CNT_INIT;
          ovf_next_d = (32'(bus.bin_in) > 32'd999999);
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        // Shifting out of the sixth nibble discards the excess; ovf covers it.
        bcd_d = (bcd_adj << 1) | {23'd0, bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = ovf_next_q;
        if (ovf_next_q) begin
          for (int i = 0; i < 6; i++) num_d[i] = GLYPH_F;
        end else begin
          // Walk from the top digit down; blanking stops at the first nonzero.
          for (int i = 5; i >= 0; i--) begin
            digit    = bcd_q[4*i +: 4];
            lz       = lz && (digit == 4'd0);
            num_d[i] = (BLANK_LZ && lz && (i != 0)) ? GLYPH_BLANK : {1'b0, digit};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < 6; i++) num_q[i] <= GLYPH_BLANK;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < 6; i++) num_q[i] <= num_d[i];
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.num0 = num_q[0];
  assign bus.num1 = num_q[1];
  assign bus.num2 = num_q[2];
  assign bus.num3 = num_q[3];
  assign bus.num4 = num_q[4];
  assign bus.num5 = num_q[5];

endmodule

// File: tb/tb_seg7_bin2num.sv
// Bench for seg7_bin2num: blanking and non-blanking instances driven in
// parallel, checked each cycle against a decimal-arithmetic reference model.
module tb_seg7_bin2num;
  localparam int BW = 20;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          load    = 1'b0;
  logic [BW-1:0] bin_in  = '0;
  logic          chk_en  = 1'b0;
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 sys_clk = ~sys_clk;

  seg7_bin2num_if #(.BIN_W(BW)) if_b ();
  seg7_bin2num_if #(.BIN_W(BW)) if_n ();

  assign if_b.load   = load;
  assign if_b.bin_in = bin_in;
  assign if_n.load   = load;
  assign if_n.bin_in = bin_in;

  seg7_bin2num #(.BIN_W(BW), .BLANK_LZ(1'b1)) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_b)
  );

  seg7_bin2num #(.BIN_W(BW), .BLANK_LZ(1'b0)) dut_n (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (if_n)
  );

  // Reference model: mk counts edges since the accepting edge (-1 = idle).
  int         mk    = -1;
  int         mval  = 0;
  logic       mbusy = 1'b0;
  logic       mdone = 1'b0;
  logic       movf  = 1'b0;
  logic [4:0] mb [6] = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16};
  logic [4:0] mn [6] = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16};

  always @(posedge sys_clk) begin
    int p;
    if (sys_rst) begin
      mk = -1; mbusy = 1'b0; mdone = 1'b0; movf = 1'b0;
      for (int i = 0; i < 6; i++) begin mb[i] = 5'd16; mn[i] = 5'd16; end
    end else begin
      mdone = 1'b0;
      if (mk < 0) begin
        if (load) begin mk = 0; mval = int'(bin_in); mbusy = 1'b1; end
      end else begin
        mk++;
        if (mk == BW + 1) begin
          mk = -1; mbusy = 1'b0; mdone = 1'b1;
          movf = (mval > 999999);
          p = 1;
          for (int i = 0; i < 6; i++) begin
            if (movf) begin
              mb[i] = 5'd15; mn[i] = 5'd15;
            end else begin
              mn[i] = 5'((mval / p) % 10);
              mb[i] = (i > 0 && mval < p) ? 5'd16 : mn[i];
            end
            p = p * 10;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [32:0] vec(input logic bz, input logic dn, input logic ov,
                                      input int d5, input int d4, input int d3,
                                      input int d2, input int d1, input int d0);
    return {bz, dn, ov, 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  function automatic logic [32:0] dut_vec_b();
    return {if_b.busy, if_b.done, if_b.ovf, if_b.num5, if_b.num4, if_b.num3,
            if_b.num2, if_b.num1, if_b.num0};
  endfunction

  function automatic logic [32:0] dut_vec_n();
    return {if_n.busy, if_n.done, if_n.ovf, if_n.num5, if_n.num4, if_n.num3,
            if_n.num2, if_n.num1, if_n.num0};
  endfunction

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("model_blank", dut_vec_b(),
          {mbusy, mdone, movf, mb[5], mb[4], mb[3], mb[2], mb[1], mb[0]});
      chk("model_noblank", dut_vec_n(),
          {mbusy, mdone, movf, mn[5], mn[4], mn[3], mn[2], mn[1], mn[0]});
    end
  end

  task automatic lit2(input string name, input logic [32:0] eb, input logic [32:0] en);
    chk({name, "_blank"}, dut_vec_b(), eb);
    chk({name, "_noblank"}, dut_vec_n(), en);
  endtask

  // Drive inputs at a falling edge, then advance past one rising edge.
  task automatic step(input logic ld, input logic [BW-1:0] v);
    load   = ld;
    bin_in = v;
    @(negedge sys_clk);
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'($urandom_range(0, 1)), BW'($urandom));
      lat++;
      if (if_b.done === 1'b1) seen = 1;
    end
    if (!seen) chk("done_timeout", 33'd0, 33'd1);
  endtask

  task automatic convert(input string name, input int v);
    int lat;
    step(1'b1, BW'(v));
    wait_done(lat);
    chk({name, "_latency"}, 33'(lat), 33'(BW + 1));
  endtask

  function automatic logic [BW-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return BW'($urandom_range(0, 1048575));
      1:       return BW'($urandom_range(0, 999));
      2:       return BW'($urandom_range(999990, 1000010));
      default: return BW'($urandom_range(0, 999999));
    endcase
  endfunction

  initial begin
    int dones;
    int lat;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    repeat (5) step(1'b0, BW'($urandom));
    lit2("reset", vec(0, 0, 0, 16, 16, 16, 16, 16, 16), vec(0, 0, 0, 16, 16, 16, 16, 16, 16));

    convert("zero", 0);
    lit2("zero", vec(0, 1, 0, 16, 16, 16, 16, 16, 0), vec(0, 1, 0, 0, 0, 0, 0, 0, 0));
    convert("v123456", 123456);
    lit2("v123456", vec(0, 1, 0, 1, 2, 3, 4, 5, 6), vec(0, 1, 0, 1, 2, 3, 4, 5, 6));
    convert("v999999", 999999);
    lit2("v999999", vec(0, 1, 0, 9, 9, 9, 9, 9, 9), vec(0, 1, 0, 9, 9, 9, 9, 9, 9));
    convert("v705", 705);
    lit2("v705", vec(0, 1, 0, 16, 16, 16, 7, 0, 5), vec(0, 1, 0, 0, 0, 0, 7, 0, 5));
    convert("v1000000", 1000000);
    lit2("v1000000", vec(0, 1, 1, 15, 15, 15, 15, 15, 15), vec(0, 1, 1, 15, 15, 15, 15, 15, 15));
    convert("v1048575", 1048575);
    lit2("v1048575", vec(0, 1, 1, 15, 15, 15, 15, 15, 15), vec(0, 1, 1, 15, 15, 15, 15, 15, 15));
    convert("v42", 42);
    lit2("v42", vec(0, 1, 0, 16, 16, 16, 16, 4, 2), vec(0, 1, 0, 0, 0, 0, 0, 4, 2));

    // Loads at E5, E20, E21 must be ignored; the one at E22 is accepted.
    step(1'b1, BW'(111111));
    dones = 0;
    for (int e = 1; e <= 22; e++) begin
      step((e == 5) || (e == 20) || (e == 21) || (e == 22), BW'(222222));
      if (if_b.done === 1'b1) dones++;
      if (e == 21)
        lit2("repulse_first", vec(0, 1, 0, 1, 1, 1, 1, 1, 1), vec(0, 1, 0, 1, 1, 1, 1, 1, 1));
    end
    chk("repulse_done_count", 33'(dones), 33'd1);
    wait_done(lat);
    chk("repulse_second_latency", 33'(lat), 33'(BW + 1));
    lit2("repulse_second", vec(0, 1, 0, 2, 2, 2, 2, 2, 2), vec(0, 1, 0, 2, 2, 2, 2, 2, 2));

    // Reset at E10 aborts the conversion.
    step(1'b1, BW'(654321));
    repeat (9) step(1'b0, BW'($urandom));
    sys_rst = 1'b1;
    step(1'b1, BW'(99));
    sys_rst = 1'b0;
    lit2("abort", vec(0, 0, 0, 16, 16, 16, 16, 16, 16), vec(0, 0, 0, 16, 16, 16, 16, 16, 16));
    dones = 0;
    repeat (25) begin
      step(1'b0, BW'($urandom));
      if (if_b.done === 1'b1) dones++;
    end
    chk("abort_no_done", 33'(dones), 33'd0);
    convert("v13", 13);
    lit2("v13", vec(0, 1, 0, 16, 16, 16, 16, 1, 3), vec(0, 1, 0, 0, 0, 0, 0, 1, 3));

    repeat (1500) begin
      sys_rst = ($urandom_range(0, 299) == 0);
      step(($urandom_range(0, 3) == 0), rand_val());
    end
    sys_rst = 1'b0;
    repeat (30) step(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
